// File: rtl/fp754_operand_unpack.sv
// Unpacks IEEE-754 single-precision operand triples into sign / +1-biased exponent / hidden-bit mantissa / class,
// buffered in a first-word-fall-through FIFO. Optional macro FP754_DENORM_FLUSH_EN flushes denormals to zero.
module fp754_operand_unpack #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [31:0]      in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       sign_out,
    output logic [7:0]       exp_a,
    output logic [7:0]       exp_b,
    output logic [7:0]       exp_c,
    output logic [23:0]      man_a,
    output logic [23:0]      man_b,
    output logic [23:0]      man_c,
    output logic [3:0]       class_a,
    output logic [3:0]       class_b,
    output logic [3:0]       class_c,
    output logic             sticky_exc,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = 3;
    localparam int DEC_W = 37;
    localparam int ENT_W = 3 * DEC_W;
    localparam logic [OCC_W-1:0] DEPTH_L = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_L  = PTR_W'(DEPTH - 1);

    // Decoded operand layout: {sign, exp+1, {hidden, fraction}, {nan, inf, zero, denorm}}
    function automatic logic [DEC_W-1:0] decode(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] f;
        logic [7:0]  ex;
        logic [23:0] m;
        logic        nan, inf, zero, den;
        e    = x[30:23];
        f    = x[22:0];
        ex   = e + 8'd1;
        m    = {(e != 8'd0), f};
        nan  = (&e) & (|f);
        inf  = (&e) & ~(|f);
        zero = ~(|e) & ~(|f);
        den  = ~(|e) & (|f);
`ifdef FP754_DENORM_FLUSH_EN
        if (den) begin
            m    = 24'd0;
            zero = 1'b1;
            den  = 1'b0;
        end
`endif
        return {x[31], ex, m, nan, inf, zero, den};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_L) ? '0 : p + 1'b1;
    endfunction

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_sticky;
    logic [CNT_W-1:0] r_op_count;

    logic [DEC_W-1:0] w_dec_a, w_dec_b, w_dec_c;
    logic [ENT_W-1:0] w_head;
    logic             w_push, w_pop, w_exc;

    assign w_dec_a = decode(in_a);
    assign w_dec_b = decode(in_b);
    assign w_dec_c = decode(in_c);

    assign in_ready  = (r_occ < DEPTH_L);
    assign out_valid = (r_occ != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_exc     = |{w_dec_a[3:2], w_dec_b[3:2], w_dec_c[3:2]};

    // Push stage: decoded triple lands in the buffer slot at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_dec_a, w_dec_b, w_dec_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_sticky   <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
            else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
            if (w_push) r_op_count <= r_op_count + 1'b1;
            if (w_push && w_exc)   r_sticky <= 1'b1;
            else if (clear_sticky) r_sticky <= 1'b0;
        end
    end

    // Head entry is zeroed while the buffer is empty so stale slots never leak out
    assign w_head = out_valid ? r_mem[r_rd_ptr] : '0;

    assign sign_out   = {w_head[110], w_head[73], w_head[36]};
    assign exp_a      = w_head[109:102];
    assign man_a      = w_head[101:78];
    assign class_a    = w_head[77:74];
    assign exp_b      = w_head[72:65];
    assign man_b      = w_head[64:41];
    assign class_b    = w_head[40:37];
    assign exp_c      = w_head[35:28];
    assign man_c      = w_head[27:4];
    assign class_c    = w_head[3:0];
    assign sticky_exc = r_sticky;
    assign op_count   = r_op_count;

endmodule

// File: doc/fp754_operand_unpack.md
Name: fp754_operand_unpack

Overview:
- Input-side counterpart to the fused multiply-add output packer.
- Accepts packed IEEE-754 single-precision operand triples (A, B, C) over a valid/ready handshake.
- Splits each operand into sign, exponent in the datapath's +1-biased convention, and 24-bit mantissa with explicit hidden bit. Also classifies each operand.
- Results are buffered in a small FIFO, so the fused datapath can stall without losing operands.

Parameters:
- DEPTH, 2, number of entries in the decoded-result buffer; legal range 1..4.
- CNT_W, 16, width of the accepted-triple counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand triple present.
- in_ready  output  1  block can accept a triple this cycle.
- in_a  input  32  packed IEEE-754 operand A.
- in_b  input  32  packed IEEE-754 operand B.
- in_c  input  32  packed IEEE-754 operand C.
- out_valid  output  1  decoded triple available at buffer head.
- out_ready  input  1  consumer takes the head entry.
- sign_out  output  3  {sA,sB,sC}.
- exp_a  output  8  biased exponent plus one, for A.
- exp_b  output  8  biased exponent plus one, for B.
- exp_c  output  8  biased exponent plus one, for C.
- man_a  output  24  {hidden, fraction} for A.
- man_b  output  24  {hidden, fraction} for B.
- man_c  output  24  {hidden, fraction} for C.
- class_a  output  4  {nan, inf, zero, denorm} for A.
- class_b  output  4  {nan, inf, zero, denorm} for B.
- class_c  output  4  {nan, inf, zero, denorm} for C.
- sticky_exc  output  1  sticky: an accepted operand was NaN or Inf.
- clear_sticky  input  1  clears sticky_exc.
- op_count  output  CNT_W  number of triples accepted since reset.

Behaviour:
- Reset (rst=1 at clk edge): buffer emptied; out_valid=0, sticky_exc=0, op_count=0.
  - Data and class outputs are 0 while out_valid=0 after reset.
  - Reset mid-stall discards all buffered entries.
- Handshake:
  - push when in_valid & in_ready; pop when out_valid & out_ready.
  - in_ready = (occupancy < DEPTH). It depends only on registered state, never on out_ready.
  - out_valid = (occupancy != 0).
- Latency: a triple pushed at edge N is visible at the outputs after edge N, i.e. out_valid high in cycle N+1. Buffer is first-word-fall-through.
- Stability: while out_valid & ~out_ready, all output fields hold unchanged.
- Simultaneous push and pop: occupancy unchanged, order preserved.
  - When full, in_ready=0, so no push occurs even if a pop happens that cycle.
- Decode per operand x, evaluated at push time:
  - e = x[30:23], f = x[22:0].
  - exp = e + 1, modulo 256, so e=255 gives 0x00.
  - hidden = (e != 0); man = {hidden, f}.
  - nan = (e==255) & (f!=0); inf = (e==255) & (f==0).
  - zero = (e==0) & (f==0); denorm = (e==0) & (f!=0).
  - Exactly one class bit or none (normal) is set.
- sticky_exc:
  - Set on a push where any operand has nan or inf.
  - Cleared by clear_sticky.
  - Set wins if clear_sticky and a qualifying push occur in the same cycle.
- op_count: increments by 1 on each push; wraps from 2^CNT_W-1 to 0. Pops do not affect it.
- Wrap pointers: read and write indices wrap modulo DEPTH. Occupancy is tracked separately, so full and empty are unambiguous.

Optional Feature:
- Macro FP754_DENORM_FLUSH_EN.
- Defined: denormal inputs are flushed at push time.
  - man = 0x000000, exp = 0x01, sign preserved.
  - class = zero (denorm bit never set).
- Undefined: denormals pass through as man = {0, f}, exp = 0x01, class = denorm.

Test Plan:
- Push A=0x3F800000, B=0x40000000, C=0x00000000 → next cycle:
  - exp_a=0x80, man_a=0x800000, class_a=0.
  - exp_b=0x81, man_b=0x800000.
  - exp_c=0x01, man_c=0x000000, class_c=4'b0010.
  - op_count=1.
- Push A=0x7F800000, B=0xFFC00000, C=0x3F800000:
  - exp_a=0x00, class_a=4'b0100.
  - class_b=4'b1000, sign_out=3'b010.
  - sticky_exc=1 and it stays 1.
  - Assert clear_sticky on a cycle with no exception push → sticky_exc=0 the next cycle.
- Push A=0x00000001 (B, C = 0x3F800000):
  - Macro undefined: man_a=0x000001, class_a=4'b0001.
  - Macro defined: man_a=0x000000, class_a=4'b0010.
- Backpressure, DEPTH=2: hold out_ready=0 and push 3 triples with in_valid held high.
  - in_ready drops after 2 pushes.
  - Head outputs stay constant.
  - Release out_ready → triples emerge in order, the third is accepted, op_count=3.
- Full-rate streaming with in_valid=out_ready=1 for 10 cycles:
  - One triple per cycle, occupancy stays 1, no bubbles.
  - Assert rst mid-stream → out_valid=0 and op_count=0 the next cycle.
- Set CNT_W=4 and push 17 triples → op_count wraps to 1.
